// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multicycle RV32I control unit.
// The master side is the control unit; the slave side is the datapath/memory.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instrCode;
  logic             dataReady;
  logic             pcEn;
  logic             irWe;
  logic             regFileWe;
  logic [3:0]       aluControl;
  logic             aluSrcMuxSel;
  logic             RFWDSrcMuxSel;
  logic             dataWe;
  logic             dataRe;
  logic             illegalInstr;
  logic [3:0]       state;
  logic [CNT_W-1:0] retireCnt;

  modport master (
    input  instrCode, dataReady,
    output pcEn, irWe, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
           dataWe, dataRe, illegalInstr, state, retireCnt
  );

  modport slave (
    output instrCode, dataReady,
    input  pcEn, irWe, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
           dataWe, dataRe, illegalInstr, state, retireCnt
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for an RV32I datapath (R-type, I-type ALU, load, store).
// Memory handshake: dataRe/dataWe are held until dataReady is sampled high at a clk edge.
module multicycle_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_unit_if.master  bus
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_R_EXE  = 4'd2,
    ST_I_EXE  = 4'd3,
    ST_S_EXE  = 4'd4,
    ST_S_MEM  = 4'd5,
    ST_L_EXE  = 4'd6,
    ST_L_MEM  = 4'd7,
    ST_L_WB   = 4'd8
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [3:0] ALU_ADD = 4'b0000;

  state_t           r_state;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic             r_f7b5;
  logic [CNT_W-1:0] r_retire_cnt;

  logic             w_retire;

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      ST_R_EXE, ST_I_EXE, ST_L_WB: w_retire = 1'b1;
      ST_S_MEM:                    w_retire = bus.dataReady;
      default:                     w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_FETCH;
      r_opcode     <= 7'd0;
      r_funct3     <= 3'd0;
      r_f7b5       <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      if (w_retire) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      case (r_state)
        ST_FETCH: begin
          r_opcode <= bus.instrCode[6:0];
          r_funct3 <= bus.instrCode[14:12];
          r_f7b5   <= bus.instrCode[30];
          r_state  <= ST_DECODE;
        end
        ST_DECODE: begin
          case (r_opcode)
            OP_R:    r_state <= ST_R_EXE;
            OP_I:    r_state <= ST_I_EXE;
            OP_S:    r_state <= ST_S_EXE;
            OP_L:    r_state <= ST_L_EXE;
            default: r_state <= ST_FETCH;
          endcase
        end
        ST_S_EXE: r_state <= ST_S_MEM;
        ST_S_MEM: if (bus.dataReady) r_state <= ST_FETCH;
        ST_L_EXE: r_state <= ST_L_MEM;
        ST_L_MEM: if (bus.dataReady) r_state <= ST_L_WB;
        default:  r_state <= ST_FETCH;
      endcase
    end
  end

  // Strobes are a pure decode of the state and latched fields, forced low during reset
  // so an abandoned instruction can never write or advance the PC.
  always_comb begin
    bus.pcEn          = 1'b0;
    bus.irWe          = 1'b0;
    bus.regFileWe     = 1'b0;
    bus.aluControl    = ALU_ADD;
    bus.aluSrcMuxSel  = 1'b0;
    bus.RFWDSrcMuxSel = 1'b0;
    bus.dataWe        = 1'b0;
    bus.dataRe        = 1'b0;
    bus.illegalInstr  = 1'b0;
    if (reset) begin
      case (r_state)
        ST_FETCH: bus.irWe = 1'b1;
        ST_DECODE: begin
          if (r_opcode != OP_R && r_opcode != OP_I &&
              r_opcode != OP_S && r_opcode != OP_L) begin
            bus.illegalInstr = 1'b1;
            bus.pcEn         = 1'b1;
          end
        end
        ST_R_EXE: begin
          bus.aluControl = {r_f7b5, r_funct3};
          bus.regFileWe  = 1'b1;
          bus.pcEn       = 1'b1;
        end
        ST_I_EXE: begin
          // Only the shift-right group uses funct7[5]; elsewhere those bits are immediate.
          bus.aluControl   = {(r_funct3 == 3'b101) ? r_f7b5 : 1'b0, r_funct3};
          bus.aluSrcMuxSel = 1'b1;
          bus.regFileWe    = 1'b1;
          bus.pcEn         = 1'b1;
        end
        ST_S_EXE, ST_L_EXE: bus.aluSrcMuxSel = 1'b1;
        ST_S_MEM: begin
          bus.aluSrcMuxSel = 1'b1;
          bus.dataWe       = 1'b1;
          bus.pcEn         = bus.dataReady;
        end
        ST_L_MEM: begin
          bus.aluSrcMuxSel = 1'b1;
          bus.dataRe       = 1'b1;
        end
        ST_L_WB: begin
          bus.RFWDSrcMuxSel = 1'b1;
          bus.regFileWe     = 1'b1;
          bus.pcEn          = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state     = r_state;
  assign bus.retireCnt = r_retire_cnt;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected cycle traces built from
// the instruction class, compared cycle by cycle against observed control outputs.
module tb_multicycle_control_unit;

  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Vector layout: {state[3:0], pcEn, irWe, regFileWe, aluControl[3:0],
  //                 aluSrcMuxSel, RFWDSrcMuxSel, dataWe, dataRe, illegalInstr}
  logic [15:0]      exp_q[$];
  logic [15:0]      obs_q[$];
  logic [CNT_W-1:0] exp_retire;

  function automatic logic [15:0] mk(input logic [3:0] st, input logic pc, input logic ir,
                                     input logic rf, input logic [3:0] alu, input logic src,
                                     input logic wd, input logic we, input logic re,
                                     input logic il);
    return {st, pc, ir, rf, alu, src, wd, we, re, il};
  endfunction

  function automatic logic [15:0] observe();
    return {bus.state, bus.pcEn, bus.irWe, bus.regFileWe, bus.aluControl,
            bus.aluSrcMuxSel, bus.RFWDSrcMuxSel, bus.dataWe, bus.dataRe, bus.illegalInstr};
  endfunction

  // ---------------- reference model ----------------
  // Expected trace of one instruction given its class and number of not-ready memory cycles.
  task automatic model_instr(input logic [31:0] instr, input int waits);
    logic [6:0] op;
    logic [2:0] f3;
    logic       b;
    logic [3:0] alu;
    op = instr[6:0];
    f3 = instr[14:12];
    b  = instr[30];
    exp_q.push_back(mk(4'd0, 0, 1, 0, 4'd0, 0, 0, 0, 0, 0));
    case (op)
      7'b0110011: begin
        exp_q.push_back(mk(4'd1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(4'd2, 1, 0, 1, {b, f3}, 0, 0, 0, 0, 0));
        exp_retire = exp_retire + 1'b1;
      end
      7'b0010011: begin
        alu = (f3 == 3'd5) ? {b, f3} : {1'b0, f3};
        exp_q.push_back(mk(4'd1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(4'd3, 1, 0, 1, alu, 1, 0, 0, 0, 0));
        exp_retire = exp_retire + 1'b1;
      end
      7'b0100011: begin
        exp_q.push_back(mk(4'd1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(4'd4, 0, 0, 0, 4'd0, 1, 0, 0, 0, 0));
        for (int i = 0; i < waits; i++) exp_q.push_back(mk(4'd5, 0, 0, 0, 4'd0, 1, 0, 1, 0, 0));
        exp_q.push_back(mk(4'd5, 1, 0, 0, 4'd0, 1, 0, 1, 0, 0));
        exp_retire = exp_retire + 1'b1;
      end
      7'b0000011: begin
        exp_q.push_back(mk(4'd1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(4'd6, 0, 0, 0, 4'd0, 1, 0, 0, 0, 0));
        for (int i = 0; i <= waits; i++) exp_q.push_back(mk(4'd7, 0, 0, 0, 4'd0, 1, 0, 0, 1, 0));
        exp_q.push_back(mk(4'd8, 1, 0, 1, 4'd0, 0, 1, 0, 0, 0));
        exp_retire = exp_retire + 1'b1;
      end
      default: exp_q.push_back(mk(4'd1, 1, 0, 0, 4'd0, 0, 0, 0, 0, 1));
    endcase
  endtask

  // ---------------- driver ----------------
  // Runs exp_q.size() cycles starting just after a rising edge. instrCode is only meaningful
  // in cycle 0, dataReady only from cycle 3 on; elsewhere both get random junk.
  task automatic drive_instr(input logic [31:0] instr, input int waits);
    int n;
    n = exp_q.size();
    obs_q.delete();
    for (int k = 0; k < n; k++) begin
      bus.instrCode = (k == 0) ? instr : $urandom;
      if (k >= 3 && k < 3 + waits) bus.dataReady = 1'b0;
      else if (k == 3 + waits)     bus.dataReady = 1'b1;
      else                         bus.dataReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      obs_q.push_back(observe());
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    bus.instrCode = 32'h002081B3;
    bus.dataReady = 1'b1;
    exp_retire = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_cnt++;
      if (observe() !== 16'h0000) $display("FAIL reset_outputs cyc %0d: got %h want 0000", k, observe());
      else pass_cnt++;
      check_cnt++;
      if (bus.retireCnt !== exp_retire) $display("FAIL reset_retire: got %0d want %0d", bus.retireCnt, exp_retire);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic test_r_type();
    exp_q.delete();
    model_instr(32'h002081B3, 0);
    drive_instr(32'h002081B3, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      check_cnt++;
      if (obs_q[k] !== exp_q[k]) $display("FAIL r_type cyc %0d: got %h want %h", k, obs_q[k], exp_q[k]);
      else pass_cnt++;
    end
    check_cnt++;
    if (bus.retireCnt !== 4'd1) $display("FAIL r_type_retire: got %0d want 1", bus.retireCnt);
    else pass_cnt++;
  endtask

  task automatic test_i_type();
    logic [31:0] instrs[2];
    logic [3:0]  alus[2];
    instrs[0] = 32'h40335293; alus[0] = 4'b1101;
    instrs[1] = 32'h00A30293; alus[1] = 4'b0000;
    for (int t = 0; t < 2; t++) begin
      exp_q.delete();
      model_instr(instrs[t], 0);
      drive_instr(instrs[t], 0);
      for (int k = 0; k < exp_q.size(); k++) begin
        check_cnt++;
        if (obs_q[k] !== exp_q[k]) $display("FAIL i_type%0d cyc %0d: got %h want %h", t, k, obs_q[k], exp_q[k]);
        else pass_cnt++;
      end
      check_cnt++;
      if (obs_q[2][8:5] !== alus[t]) $display("FAIL i_type%0d_alu: got %b want %b", t, obs_q[2][8:5], alus[t]);
      else pass_cnt++;
      check_cnt++;
      if (bus.retireCnt !== exp_retire) $display("FAIL i_type%0d_retire: got %0d want %0d", t, bus.retireCnt, exp_retire);
      else pass_cnt++;
    end
  endtask

  task automatic test_store();
    int we_cnt;
    exp_q.delete();
    model_instr(32'h0020A423, 2);
    drive_instr(32'h0020A423, 2);
    we_cnt = 0;
    check_cnt++;
    if (obs_q.size() !== 6) $display("FAIL store_len: got %0d want 6", obs_q.size());
    else pass_cnt++;
    for (int k = 0; k < exp_q.size(); k++) begin
      we_cnt += int'(obs_q[k][2]);
      check_cnt++;
      if (obs_q[k] !== exp_q[k]) $display("FAIL store cyc %0d: got %h want %h", k, obs_q[k], exp_q[k]);
      else pass_cnt++;
    end
    check_cnt++;
    if (we_cnt !== 3) $display("FAIL store_we_cycles: got %0d want 3", we_cnt);
    else pass_cnt++;
    check_cnt++;
    if (bus.retireCnt !== exp_retire) $display("FAIL store_retire: got %0d want %0d", bus.retireCnt, exp_retire);
    else pass_cnt++;
  endtask

  task automatic test_load();
    exp_q.delete();
    model_instr(32'h0040A203, 0);
    drive_instr(32'h0040A203, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      check_cnt++;
      if (obs_q[k] !== exp_q[k]) $display("FAIL load cyc %0d: got %h want %h", k, obs_q[k], exp_q[k]);
      else pass_cnt++;
    end
    check_cnt++;
    if (bus.retireCnt !== exp_retire) $display("FAIL load_retire: got %0d want %0d", bus.retireCnt, exp_retire);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    exp_q.delete();
    model_instr(32'h0000007F, 0);
    drive_instr(32'h0000007F, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      check_cnt++;
      if (obs_q[k] !== exp_q[k]) $display("FAIL illegal cyc %0d: got %h want %h", k, obs_q[k], exp_q[k]);
      else pass_cnt++;
    end
    check_cnt++;
    if (bus.retireCnt !== exp_retire) $display("FAIL illegal_retire: got %0d want %0d", bus.retireCnt, exp_retire);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    exp_q.delete();
    model_instr(32'h0040A203, 5);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    drive_instr(32'h0040A203, 5);
    for (int k = 0; k < exp_q.size(); k++) begin
      check_cnt++;
      if (obs_q[k] !== exp_q[k]) $display("FAIL midrst_pre cyc %0d: got %h want %h", k, obs_q[k], exp_q[k]);
      else pass_cnt++;
    end
    reset = 1'b0;
    bus.dataReady = 1'b1;
    @(negedge clk);
    check_cnt++;
    if (observe() !== 16'h7000) $display("FAIL midrst_gated: got %h want 7000", observe());
    else pass_cnt++;
    @(posedge clk);
    #1;
    exp_retire = '0;
    @(negedge clk);
    check_cnt++;
    if (observe() !== 16'h0000) $display("FAIL midrst_fetch: got %h want 0000", observe());
    else pass_cnt++;
    check_cnt++;
    if (bus.retireCnt !== exp_retire) $display("FAIL midrst_retire: got %0d want 0", bus.retireCnt);
    else pass_cnt++;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_random_stream();
    logic [31:0] instr;
    logic [6:0]  op;
    int          waits;
    for (int n = 0; n < 40; n++) begin
      instr = $urandom;
      case ($urandom_range(0, 4))
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = 7'b0100011;
        3: op = 7'b0000011;
        default: begin
          op = 7'($urandom_range(0, 127));
          while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0100011 || op == 7'b0000011)
            op = 7'($urandom_range(0, 127));
        end
      endcase
      instr[6:0] = op;
      waits = $urandom_range(0, 3);
      exp_q.delete();
      model_instr(instr, waits);
      drive_instr(instr, waits);
      for (int k = 0; k < exp_q.size(); k++) begin
        check_cnt++;
        if (obs_q[k] !== exp_q[k])
          $display("FAIL random%0d instr %h cyc %0d: got %h want %h", n, instr, k, obs_q[k], exp_q[k]);
        else pass_cnt++;
      end
      check_cnt++;
      if (bus.retireCnt !== exp_retire)
        $display("FAIL random%0d_retire: got %0d want %0d", n, bus.retireCnt, exp_retire);
      else pass_cnt++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_store();
    test_load();
    test_illegal();
    test_reset_mid_load();
    test_random_stream();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle control FSM for the RV32I datapath; replaces single-cycle decode.
- Latches the opcode fields of each fetched instruction and steps through fetch/decode/execute/memory/writeback states.
- Drives the PC enable, IR load, register-file write enable, ALU control, mux selects and data-memory strobes.
- Supports R-type, I-type ALU, load and store, with a wait handshake on data memory and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- instrCode  in  32  instruction word from instruction memory, valid in FETCH
- dataReady  in  1  data memory done; sampled in L_MEM/S_MEM
- pcEn  out  1  PC register load (PC <= PC+4)
- irWe  out  1  instruction register load
- regFileWe  out  1  register-file write enable
- aluControl  out  4  ALU operation, {funct7[5]-derived bit, funct3} encoding
- aluSrcMuxSel  out  1  0 = RData2, 1 = immediate
- RFWDSrcMuxSel  out  1  0 = ALU result, 1 = memory read data
- dataWe  out  1  data memory write strobe
- dataRe  out  1  data memory read strobe
- illegalInstr  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current FSM state (debug)
- retireCnt  out  CNT_W  count of legally completed instructions

Behaviour:
- Reset: reset==0 at a clk edge forces state=FETCH, retireCnt=0 and the latched fields to 0. All strobe outputs are 0 while in reset and combinationally follow the state afterwards. Reset mid-instruction abandons it with no write or pcEn.
- State codes:
  - FETCH=0, DECODE=1, R_EXE=2, I_EXE=3, S_EXE=4, S_MEM=5, L_EXE=6, L_MEM=7, L_WB=8.
  - Codes 9–15 are unreachable and go to FETCH.
- FETCH:
  - irWe=1; latch opcode=instrCode[6:0], funct3=instrCode[14:12], f7b5=instrCode[30].
  - Next state is DECODE.
- DECODE: branch on the latched opcode.
  - 0110011 -> R_EXE
  - 0010011 -> I_EXE
  - 0100011 -> S_EXE
  - 0000011 -> L_EXE
  - Any other opcode: illegalInstr=1 and pcEn=1 (skip the instruction), retireCnt unchanged, next state FETCH.
- R_EXE: aluControl={f7b5,funct3}, aluSrcMuxSel=0, regFileWe=1, pcEn=1, retire; next state FETCH.
- I_EXE: aluControl={(funct3==101)?f7b5:0, funct3}, aluSrcMuxSel=1, regFileWe=1, pcEn=1, retire; next state FETCH.
- S_EXE: aluControl=ADD (0000), aluSrcMuxSel=1; next state S_MEM.
- S_MEM:
  - aluControl=ADD, aluSrcMuxSel=1, dataWe=1.
  - Stays in S_MEM while dataReady==0.
  - When dataReady==1: pcEn=1, retire, next state FETCH.
- L_EXE: aluControl=ADD, aluSrcMuxSel=1; next state L_MEM.
- L_MEM:
  - aluControl=ADD, aluSrcMuxSel=1, dataRe=1.
  - Stays in L_MEM while dataReady==0; when dataReady==1, next state L_WB.
- L_WB: RFWDSrcMuxSel=1, regFileWe=1, pcEn=1, retire; next state FETCH.
- Default values: every output not listed for a state is 0, and aluControl defaults to 0000.
- ALU codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Latency, counting dataReady=1 on first sample: R/I = 3 cycles, S = 4, L = 5. Each dataReady=0 cycle adds 1.
- pcEn is asserted exactly once per instruction, including illegal ones.
- regFileWe and dataWe are never asserted in the same cycle.
- Retire: retireCnt increments by 1 in the cycle the FSM leaves a final state. It wraps from 2^CNT_W-1 to 0.
- dataReady is ignored outside L_MEM/S_MEM.
- instrCode is ignored outside FETCH.

Test Plan:
- Reset low 2 cycles, then high, with R-type add x3,x1,x2 (0x002081B3) -> state 0,1,2; in cycle 3 aluControl=0000, regFileWe=1, pcEn=1; retireCnt=1.
- I-type srai x5,x6,3 (0x40335293) -> in I_EXE aluControl=1101, aluSrcMuxSel=1, regFileWe=1; addi 0x00A30293 -> aluControl=0000.
- sw x2,8(x1) (0x0020A423) with dataReady low 2 cycles then high -> dataWe=1 for 3 cycles; pcEn only in the last; total 6 cycles; regFileWe never 1.
- lw x4,4(x1) (0x0040A203) with dataReady=1 -> dataRe in cycle 4; RFWDSrcMuxSel=1, regFileWe=1, pcEn=1 in cycle 5; retireCnt+1.
- Opcode 0x7F -> illegalInstr=1 and pcEn=1 in DECODE, back to FETCH; retireCnt unchanged.
- reset=0 asserted while in L_MEM -> next edge state=FETCH, retireCnt=0; no regFileWe or pcEn pulse.
